// File: rtl/memory_stage.sv
// EX/MEM pipeline register plus data-memory access stage of the 5-stage MIPS pipeline.
// Holds a cache request until dhit, stalls upstream meanwhile, and registers the MEM/WB bundle.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        memen,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [31:0] ex_ALUOut,
    input  logic [31:0] ex_dmemstore,
    input  logic        ex_dREN,
    input  logic        ex_dWEN,
    input  logic        ex_regWr,
    input  logic [1:0]  ex_regSel,
    input  logic [4:0]  ex_regDst,
    input  logic [31:0] ex_nPC,
    input  logic [31:0] ex_lui,
    input  logic        ex_halt,
    input  logic [31:0] ex_instr,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        fwd_regWr,
    output logic [4:0]  fwd_regDst,
    output logic [31:0] fwd_data,
    output logic        wb_regWr,
    output logic [4:0]  wb_regDst,
    output logic [31:0] wb_wdat,
    output logic        wb_halt,
    output logic [31:0] wb_instr,
    output logic        mem_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StHeld = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [31:0]   r_ldbuf;

    logic          r_m_valid;
    logic [31:0]   r_m_aluout;
    logic [31:0]   r_m_store;
    logic          r_m_dren;
    logic          r_m_dwen;
    logic          r_m_regwr;
    logic [1:0]    r_m_regsel;
    logic [4:0]    r_m_regdst;
    logic [31:0]   r_m_npc;
    logic [31:0]   r_m_lui;
    logic          r_m_halt;
    logic [31:0]   r_m_instr;

    logic          r_wb_regwr;
    logic [4:0]    r_wb_regdst;
    logic [31:0]   r_wb_wdat;
    logic          r_wb_halt;
    logic [31:0]   r_wb_instr;

    logic          w_in_req;
    logic          w_held;
    logic          w_stall;
    logic          w_adv;
    logic          w_ex_memop;
    logic          w_req_ok;
    logic [1:0]    w_state_nxt;
    logic [31:0]   w_wdat;
    logic [31:0]   w_fwd;

    assign w_in_req   = (r_state == StReq);
    assign w_held     = (r_state == StHeld);
    assign w_stall    = w_in_req & ~dhit;
    assign w_adv      = memen & ~w_stall;
    assign w_ex_memop = ex_valid & (ex_dREN | ex_dWEN);
    // Requests drop combinationally so a reset/flush never lets the access complete.
    assign w_req_ok   = w_in_req & ~flush & ~RST;

    assign dmemREN    = w_req_ok & r_m_dren;
    assign dmemWEN    = w_req_ok & r_m_dwen & ~r_m_dren;
    assign dmemaddr   = r_m_aluout;
    assign dmemstore  = r_m_store;
    assign mem_stall  = w_stall;

    assign fwd_regDst = r_m_regdst;
    assign fwd_regWr  = r_m_valid & r_m_regwr & (r_m_regdst != 5'd0) &
                        ~((r_m_regsel == 2'd1) & ~w_held);
    assign fwd_data   = w_fwd;

    assign wb_regWr   = r_wb_regwr;
    assign wb_regDst  = r_wb_regdst;
    assign wb_wdat    = r_wb_wdat;
    assign wb_halt    = r_wb_halt;
    assign wb_instr   = r_wb_instr;
    assign mem_err    = r_err;

    always_comb begin
        w_state_nxt = r_state;
        if (w_adv) begin
            w_state_nxt = w_ex_memop ? StReq : StIdle;
        end else if (w_in_req && dhit) begin
            w_state_nxt = StHeld;
        end
    end

    always_comb begin
        w_wdat = r_m_aluout;
        w_fwd  = r_m_aluout;
        case (r_m_regsel)
            2'd1: begin
                w_wdat = w_held ? r_ldbuf : dmemload;
                w_fwd  = r_ldbuf;
            end
            2'd2: begin
                w_wdat = r_m_npc;
                w_fwd  = r_m_npc;
            end
            2'd3: begin
                w_wdat = r_m_lui;
                w_fwd  = r_m_lui;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_ldbuf     <= '0;
            r_m_valid   <= 1'b0;
            r_m_aluout  <= '0;
            r_m_store   <= '0;
            r_m_dren    <= 1'b0;
            r_m_dwen    <= 1'b0;
            r_m_regwr   <= 1'b0;
            r_m_regsel  <= '0;
            r_m_regdst  <= '0;
            r_m_npc     <= '0;
            r_m_lui     <= '0;
            r_m_halt    <= 1'b0;
            r_m_instr   <= '0;
            r_wb_regwr  <= 1'b0;
            r_wb_regdst <= '0;
            r_wb_wdat   <= '0;
            r_wb_halt   <= 1'b0;
            r_wb_instr  <= '0;
        end else begin
            r_wb_regwr <= 1'b0;
            if (flush) begin
                r_state    <= StIdle;
                r_cnt      <= '0;
                r_m_valid  <= 1'b0;
                r_m_dren   <= 1'b0;
                r_m_dwen   <= 1'b0;
                r_m_regwr  <= 1'b0;
                r_m_regsel <= '0;
                r_m_halt   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (w_adv) begin
                    r_wb_regwr  <= r_m_valid & r_m_regwr & (r_m_regdst != 5'd0);
                    r_wb_regdst <= r_m_regdst;
                    r_wb_wdat   <= w_wdat;
                    r_wb_instr  <= r_m_instr;
                    if (r_m_valid && r_m_halt) r_wb_halt <= 1'b1;
                    // Invalid execute bundles enter M as bubbles with all controls cleared.
                    r_m_valid  <= ex_valid;
                    r_m_aluout <= ex_ALUOut;
                    r_m_store  <= ex_dmemstore;
                    r_m_dren   <= ex_valid & ex_dREN;
                    r_m_dwen   <= ex_valid & ex_dWEN;
                    r_m_regwr  <= ex_valid & ex_regWr;
                    r_m_regsel <= ex_valid ? ex_regSel : 2'd0;
                    r_m_regdst <= ex_regDst;
                    r_m_npc    <= ex_nPC;
                    r_m_lui    <= ex_lui;
                    r_m_halt   <= ex_valid & ex_halt;
                    r_m_instr  <= ex_instr;
                    r_cnt      <= '0;
                end else begin
                    if (w_in_req && dhit) r_ldbuf <= dmemload;
                    if (w_stall) begin
                        if (r_cnt == CMAX) r_err <= 1'b1;
                        else r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: ALU path, loads, stores, HELD, flush,
// halt, $0 writes, back-to-back memops and request timeout.
module tb_memory_stage;

    localparam int unsigned TO = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        memen = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_ALUOut = '0;
    logic [31:0] ex_dmemstore = '0;
    logic        ex_dREN = 1'b0;
    logic        ex_dWEN = 1'b0;
    logic        ex_regWr = 1'b0;
    logic [1:0]  ex_regSel = '0;
    logic [4:0]  ex_regDst = '0;
    logic [31:0] ex_nPC = '0;
    logic [31:0] ex_lui = '0;
    logic        ex_halt = 1'b0;
    logic [31:0] ex_instr = '0;
    logic        dhit = 1'b0;
    logic [31:0] dmemload = '0;
    logic        dmemREN, dmemWEN, mem_stall, fwd_regWr, wb_regWr, wb_halt, mem_err;
    logic [31:0] dmemaddr, dmemstore, fwd_data, wb_wdat, wb_instr;
    logic [4:0]  fwd_regDst, wb_regDst;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .memen(memen), .flush(flush), .ex_valid(ex_valid),
        .ex_ALUOut(ex_ALUOut), .ex_dmemstore(ex_dmemstore), .ex_dREN(ex_dREN),
        .ex_dWEN(ex_dWEN), .ex_regWr(ex_regWr), .ex_regSel(ex_regSel),
        .ex_regDst(ex_regDst), .ex_nPC(ex_nPC), .ex_lui(ex_lui), .ex_halt(ex_halt),
        .ex_instr(ex_instr), .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .fwd_regWr(fwd_regWr), .fwd_regDst(fwd_regDst),
        .fwd_data(fwd_data), .wb_regWr(wb_regWr), .wb_regDst(wb_regDst),
        .wb_wdat(wb_wdat), .wb_halt(wb_halt), .wb_instr(wb_instr), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (dmemWEN) wr_cnt++;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] st,
                          input logic rd, input logic wr, input logic rw,
                          input logic [1:0] sel, input logic [4:0] dst);
        ex_valid = v; ex_ALUOut = alu; ex_dmemstore = st; ex_dREN = rd; ex_dWEN = wr;
        ex_regWr = rw; ex_regSel = sel; ex_regDst = dst; ex_halt = 1'b0;
        ex_nPC = 32'h0; ex_lui = 32'h0; ex_instr = 32'h0;
    endtask

    task automatic set_idle();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
    endtask

    task automatic test_reset();
        logic [176:0] outs;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
        outs = {dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, fwd_regWr, fwd_regDst,
                fwd_data, wb_regWr, wb_regDst, wb_wdat, wb_halt, wb_instr, mem_err};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", outs);
        end
    endtask

    task automatic test_alu();
        set_ex(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd5);
        memen = 1'b1;
        step();
        set_idle();
        #1;
        checks++;
        if ({dmemREN, mem_stall, fwd_regWr, fwd_regDst, fwd_data} !== {3'b001, 5'd5, 32'h1234})
        begin
            errors++;
            $display("FAIL alu_fwd: got ren=%b stall=%b fwr=%b dst=%0d dat=%h required 0 0 1 5 1234",
                     dmemREN, mem_stall, fwd_regWr, fwd_regDst, fwd_data);
        end
        step();
        checks++;
        if ({wb_regWr, wb_regDst, wb_wdat} !== {1'b1, 5'd5, 32'h1234}) begin
            errors++;
            $display("FAIL alu_wb: got wr=%b dst=%0d wdat=%h required 1 5 1234",
                     wb_regWr, wb_regDst, wb_wdat);
        end
        step();
        checks++;
        if (wb_regWr !== 1'b0) begin
            errors++; $display("FAIL alu_bubble: got wb_regWr=%b required 0", wb_regWr);
        end
    endtask

    task automatic test_load();
        set_ex(1'b1, 32'h80, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd8);
        memen = 1'b1;
        step();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({dmemREN, mem_stall, dmemaddr, fwd_regWr, wb_regWr} !== {2'b11, 32'h80, 2'b00})
            begin
                errors++;
                $display("FAIL load_stall[%0d]: got ren=%b stall=%b addr=%h fwr=%b wbwr=%b required 1 1 80 0 0",
                         i, dmemREN, mem_stall, dmemaddr, fwd_regWr, wb_regWr);
            end
            step();
        end
        dhit = 1'b1;
        dmemload = 32'hDEADBEEF;
        #1;
        checks++;
        if ({dmemREN, mem_stall} !== 2'b10) begin
            errors++;
            $display("FAIL load_hit: got ren=%b stall=%b required 1 0", dmemREN, mem_stall);
        end
        step();
        dhit = 1'b0;
        dmemload = 32'h0;
        #1;
        checks++;
        if ({wb_regWr, wb_regDst, wb_wdat, dmemREN} !== {1'b1, 5'd8, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL load_wb: got wr=%b dst=%0d wdat=%h ren=%b required 1 8 deadbeef 0",
                     wb_regWr, wb_regDst, wb_wdat, dmemREN);
        end
    endtask

    task automatic test_store_held();
        wr_cnt = 0;
        set_ex(1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0);
        ex_instr = 32'hAC000040;
        memen = 1'b1;
        step();
        set_idle();
        memen = 1'b0;
        dhit = 1'b1;
        #1;
        checks++;
        if ({dmemWEN, dmemREN, mem_stall, dmemstore, dmemaddr} !== {3'b100, 32'hCAFEF00D, 32'h40})
        begin
            errors++;
            $display("FAIL store_req: got wen=%b ren=%b stall=%b data=%h addr=%h required 1 0 0 cafef00d 40",
                     dmemWEN, dmemREN, mem_stall, dmemstore, dmemaddr);
        end
        step();
        dhit = 1'b0;
        #1;
        checks++;
        if ({dmemWEN, mem_stall, wb_regWr} !== 3'b000) begin
            errors++;
            $display("FAIL store_held: got wen=%b stall=%b wbwr=%b required 0 0 0",
                     dmemWEN, mem_stall, wb_regWr);
        end
        step();
        checks++;
        if ({dmemWEN, wb_instr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL store_held2: got wen=%b wb_instr=%h required 0 0", dmemWEN, wb_instr);
        end
        memen = 1'b1;
        step();
        #1;
        checks++;
        if ({wb_instr, wb_regWr, dmemWEN} !== {32'hAC000040, 2'b00}) begin
            errors++;
            $display("FAIL store_adv: got wb_instr=%h wbwr=%b wen=%b required ac000040 0 0",
                     wb_instr, wb_regWr, dmemWEN);
        end
        checks++;
        if (wr_cnt !== 1) begin
            errors++; $display("FAIL store_once: got %0d write cycles required 1", wr_cnt);
        end
    endtask

    task automatic test_load_held();
        set_ex(1'b1, 32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd9);
        memen = 1'b1;
        step();
        set_idle();
        memen = 1'b0;
        dhit = 1'b1;
        dmemload = 32'h55AA55AA;
        step();
        dhit = 1'b0;
        dmemload = 32'hFFFFFFFF;
        #1;
        checks++;
        if ({dmemREN, mem_stall, fwd_regWr, fwd_data} !== {3'b001, 32'h55AA55AA}) begin
            errors++;
            $display("FAIL lheld_fwd: got ren=%b stall=%b fwr=%b dat=%h required 0 0 1 55aa55aa",
                     dmemREN, mem_stall, fwd_regWr, fwd_data);
        end
        memen = 1'b1;
        step();
        checks++;
        if ({wb_regWr, wb_regDst, wb_wdat} !== {1'b1, 5'd9, 32'h55AA55AA}) begin
            errors++;
            $display("FAIL lheld_wb: got wr=%b dst=%0d wdat=%h required 1 9 55aa55aa",
                     wb_regWr, wb_regDst, wb_wdat);
        end
        dmemload = 32'h0;
    endtask

    task automatic test_back_to_back();
        set_ex(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd10);
        memen = 1'b1;
        step();
        set_ex(1'b1, 32'h104, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd11);
        dhit = 1'b1;
        dmemload = 32'h11111111;
        #1;
        checks++;
        if ({mem_stall, dmemREN, dmemaddr} !== {2'b01, 32'h100}) begin
            errors++;
            $display("FAIL b2b_first: got stall=%b ren=%b addr=%h required 0 1 100",
                     mem_stall, dmemREN, dmemaddr);
        end
        step();
        set_idle();
        dhit = 1'b0;
        #1;
        checks++;
        if ({wb_regWr, wb_regDst, wb_wdat, dmemREN, mem_stall, dmemaddr} !==
            {1'b1, 5'd10, 32'h11111111, 2'b11, 32'h104}) begin
            errors++;
            $display("FAIL b2b_second: got wr=%b dst=%0d wdat=%h ren=%b stall=%b addr=%h required 1 10 11111111 1 1 104",
                     wb_regWr, wb_regDst, wb_wdat, dmemREN, mem_stall, dmemaddr);
        end
        dhit = 1'b1;
        dmemload = 32'h22222222;
        step();
        dhit = 1'b0;
        dmemload = 32'h0;
        checks++;
        if ({wb_regWr, wb_regDst, wb_wdat} !== {1'b1, 5'd11, 32'h22222222}) begin
            errors++;
            $display("FAIL b2b_wb: got wr=%b dst=%0d wdat=%h required 1 11 22222222",
                     wb_regWr, wb_regDst, wb_wdat);
        end
    endtask

    task automatic test_flush();
        set_ex(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd3);
        memen = 1'b1;
        step();
        set_idle();
        step();
        flush = 1'b1;
        #1;
        checks++;
        if (dmemREN !== 1'b0) begin
            errors++; $display("FAIL flush_same_cycle: got ren=%b required 0", dmemREN);
        end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if ({dmemREN, mem_stall, wb_regWr} !== 3'b000) begin
            errors++;
            $display("FAIL flush_after: got ren=%b stall=%b wbwr=%b required 0 0 0",
                     dmemREN, mem_stall, wb_regWr);
        end
        step();
        checks++;
        if (wb_regWr !== 1'b0) begin
            errors++; $display("FAIL flush_nowb: got wbwr=%b required 0", wb_regWr);
        end
    endtask

    task automatic test_halt_zero();
        set_ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        ex_halt = 1'b1;
        memen = 1'b1;
        step();
        set_idle();
        step();
        checks++;
        if (wb_halt !== 1'b1) begin
            errors++; $display("FAIL halt_set: got wb_halt=%b required 1", wb_halt);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        checks++;
        if (wb_halt !== 1'b1) begin
            errors++; $display("FAIL halt_sticky: got wb_halt=%b required 1", wb_halt);
        end
        set_ex(1'b1, 32'h99, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd0);
        step();
        set_idle();
        #1;
        checks++;
        if (fwd_regWr !== 1'b0) begin
            errors++; $display("FAIL zero_fwd: got fwd_regWr=%b required 0", fwd_regWr);
        end
        step();
        checks++;
        if ({wb_regWr, wb_wdat} !== {1'b0, 32'h99}) begin
            errors++;
            $display("FAIL zero_wb: got wr=%b wdat=%h required 0 99", wb_regWr, wb_wdat);
        end
    endtask

    task automatic test_timeout();
        logic [176:0] outs;
        set_ex(1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd4);
        memen = 1'b1;
        step();
        set_idle();
        repeat (TO - 1) step();
        checks++;
        if (mem_err !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got mem_err=%b required 0", mem_err);
        end
        step();
        checks++;
        if ({mem_err, dmemREN, mem_stall} !== 3'b111) begin
            errors++;
            $display("FAIL timeout_set: got err=%b ren=%b stall=%b required 1 1 1",
                     mem_err, dmemREN, mem_stall);
        end
        step();
        checks++;
        if (mem_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got mem_err=%b required 1", mem_err);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        memen = 1'b0;
        #1;
        outs = {dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, fwd_regWr, fwd_regDst,
                fwd_data, wb_regWr, wb_regDst, wb_wdat, wb_halt, wb_instr, mem_err};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL timeout_reset: got %h required 0", outs);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_held();
        test_load_held();
        test_back_to_back();
        test_flush();
        test_halt_zero();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
